// File: rtl/qsys_mult_pkg.sv
// Shared constants for the Nios II style multiply unit: op encodings and pipeline depth.
package qsys_mult_pkg;

    localparam int unsigned OP_W        = 2;
    localparam int unsigned MULT_STAGES = 3;

    localparam logic [OP_W-1:0] OP_MUL    = 2'd0;
    localparam logic [OP_W-1:0] OP_MULXSS = 2'd1;
    localparam logic [OP_W-1:0] OP_MULXSU = 2'd2;
    localparam logic [OP_W-1:0] OP_MULXUU = 2'd3;

endpackage

// File: rtl/qsys_nios2_mult_unit_if.sv
// Operand/result handshake bundle for the multiply unit; master drives operands, slave is the unit.
interface qsys_nios2_mult_unit_if
    import qsys_mult_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 5
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [OP_W-1:0]   in_op;
    logic [TAG_W-1:0]  in_tag;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [TAG_W-1:0]  out_tag;
    logic              busy;

    modport master (
        output in_valid, in_a, in_b, in_op, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_result, out_tag, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_tag, flush, out_ready,
        output in_ready, out_valid, out_result, out_tag, busy
    );

endinterface

// File: rtl/qsys_mult_partial.sv
// One registered W x W unsigned partial-product multiplier with load enable.
module qsys_mult_partial #(
    parameter int unsigned W = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [2*W-1:0] p_o
);

    localparam int unsigned P_W = 2 * W;

    logic [P_W-1:0] p_d;

    assign p_d = P_W'(a_i) * P_W'(b_i);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_o <= '0;
        end else if (en_i) begin
            p_o <= p_d;
        end
    end

endmodule

// File: rtl/qsys_nios2_mult_unit.sv
// Three-stage pipelined multiplier: S1 partial products + sign correction term,
// S2 full double-width product, S3 selected result word.
module qsys_nios2_mult_unit
    import qsys_mult_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    qsys_nios2_mult_unit_if.slave bus
);

    localparam int unsigned HALF_W = DATA_W / 2;
    localparam int unsigned PROD_W = 2 * DATA_W;

    logic              adv;
    logic [HALF_W-1:0] a_lo, a_hi, b_lo, b_hi;
    logic [DATA_W-1:0] pp_ll, pp_lh, pp_hl, pp_hh;
    logic              a_neg, b_neg;
    logic [DATA_W-1:0] corr_d;
    logic [PROD_W-1:0] prod_d;
    logic [DATA_W-1:0] res_d;

    logic              v1_q, v2_q, v3_q;
    logic [OP_W-1:0]   op1_q, op2_q;
    logic [TAG_W-1:0]  tag1_q, tag2_q, tag3_q;
    logic [DATA_W-1:0] corr1_q;
    logic [PROD_W-1:0] prod_q;
    logic [DATA_W-1:0] res_q;

    assign adv = ~v3_q | bus.out_ready;

    assign a_lo = bus.in_a[HALF_W-1:0];
    assign a_hi = bus.in_a[DATA_W-1:HALF_W];
    assign b_lo = bus.in_b[HALF_W-1:0];
    assign b_hi = bus.in_b[DATA_W-1:HALF_W];

    qsys_mult_partial #(.W(HALF_W)) u_pp_ll (
        .clk(clk), .reset(reset), .en_i(adv), .a_i(a_lo), .b_i(b_lo), .p_o(pp_ll)
    );
    qsys_mult_partial #(.W(HALF_W)) u_pp_lh (
        .clk(clk), .reset(reset), .en_i(adv), .a_i(a_lo), .b_i(b_hi), .p_o(pp_lh)
    );
    qsys_mult_partial #(.W(HALF_W)) u_pp_hl (
        .clk(clk), .reset(reset), .en_i(adv), .a_i(a_hi), .b_i(b_lo), .p_o(pp_hl)
    );
    qsys_mult_partial #(.W(HALF_W)) u_pp_hh (
        .clk(clk), .reset(reset), .en_i(adv), .a_i(a_hi), .b_i(b_hi), .p_o(pp_hh)
    );

    // Signed correction only touches the upper word, so it is kept modulo 2^DATA_W.
    assign a_neg  = bus.in_a[DATA_W-1] & ((bus.in_op == OP_MULXSS) | (bus.in_op == OP_MULXSU));
    assign b_neg  = bus.in_b[DATA_W-1] & (bus.in_op == OP_MULXSS);
    assign corr_d = (a_neg ? bus.in_b : '0) + (b_neg ? bus.in_a : '0);

    assign prod_d = {pp_hh, pp_ll}
                  + (PROD_W'(pp_lh) << HALF_W)
                  + (PROD_W'(pp_hl) << HALF_W)
                  - {corr1_q, {DATA_W{1'b0}}};

    assign res_d = (op2_q == OP_MUL) ? prod_q[DATA_W-1:0] : prod_q[PROD_W-1:DATA_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            tag1_q  <= '0;
            tag2_q  <= '0;
            tag3_q  <= '0;
            corr1_q <= '0;
            prod_q  <= '0;
            res_q   <= '0;
        end else begin
            if (bus.flush) begin
                v1_q <= 1'b0;
                v2_q <= 1'b0;
                v3_q <= 1'b0;
            end else if (adv) begin
                v1_q <= bus.in_valid;
                v2_q <= v1_q;
                v3_q <= v2_q;
            end
            if (adv) begin
                op1_q   <= bus.in_op;
                tag1_q  <= bus.in_tag;
                corr1_q <= corr_d;
                op2_q   <= op1_q;
                tag2_q  <= tag1_q;
                prod_q  <= prod_d;
                res_q   <= res_d;
                tag3_q  <= tag2_q;
            end
        end
    end

    assign bus.in_ready   = adv;
    assign bus.out_valid  = v3_q;
    assign bus.out_result = res_q;
    assign bus.out_tag    = tag3_q;
    assign bus.busy       = v1_q | v2_q | v3_q;

endmodule

// File: tb/tb_qsys_nios2_mult_unit.sv
// Directed bench for qsys_nios2_mult_unit (DATA_W=32) with an in-order result scoreboard.
module tb_qsys_nios2_mult_unit;
    import qsys_mult_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
    } exp_t;

    logic clk;
    logic reset;
    int   n_tot;
    int   n_bad;
    int   n_out;
    int   cyc;
    int   first_cyc;
    int   last_cyc;
    exp_t sb_q[$];

    qsys_nios2_mult_unit_if #(.DATA_W(32), .TAG_W(5)) bus ();

    qsys_nios2_mult_unit #(.DATA_W(32), .TAG_W(5)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Independent reference using 64-bit signed/unsigned arithmetic.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] p;
        case (op)
            OP_MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            OP_MULXSS: begin sa = $signed({{32{a[31]}}, a}); sb = $signed({{32{b[31]}}, b}); p = sa * sb; return p[63:32]; end
            OP_MULXSU: begin sa = $signed({{32{a[31]}}, a}); sb = $signed({32'b0, b}); p = sa * sb; return p[63:32]; end
            default:   begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
        endcase
    endfunction

    // Scoreboard/monitor sampled on the falling edge, away from the active edge.
    initial begin
        bit          stall_prev;
        logic [31:0] held_res;
        logic [4:0]  held_tag;
        exp_t        e;
        stall_prev = 1'b0;
        held_res   = '0;
        held_tag   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                sb_q.delete();
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("hold_valid", 64'(bus.out_valid), 64'(1));
                    chk("hold_result", 64'(bus.out_result), 64'(held_res));
                    chk("hold_tag", 64'(bus.out_tag), 64'(held_tag));
                end
                stall_prev = bus.out_valid && !bus.out_ready;
                held_res   = bus.out_result;
                held_tag   = bus.out_tag;
                if (bus.out_valid && bus.out_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("spurious_out", 64'(bus.out_valid), 64'(0));
                    end else begin
                        e = sb_q.pop_front();
                        chk("sb_result", 64'(bus.out_result), 64'(e.res));
                        chk("sb_tag", 64'(bus.out_tag), 64'(e.tag));
                        if (n_out == 0) first_cyc = cyc;
                        last_cyc = cyc;
                        n_out++;
                    end
                end
                if (bus.flush) begin
                    sb_q.delete();
                end else if (bus.in_valid && bus.in_ready) begin
                    e.res = ref_mul(bus.in_op, bus.in_a, bus.in_b);
                    e.tag = bus.in_tag;
                    sb_q.push_back(e);
                end
            end
        end
    end

    // Present one operand set and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        int n;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Single op with exact 3-cycle latency check against a hand-computed value.
    task automatic one_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic [31:0] exp);
        send(op, a, b, tag);
        @(posedge clk);
        @(negedge clk);
        chk({name, "_early"}, 64'(bus.out_valid), 64'(0));
        @(negedge clk);
        chk({name, "_valid"}, 64'(bus.out_valid), 64'(1));
        chk({name, "_result"}, 64'(bus.out_result), 64'(exp));
        chk({name, "_tag"}, 64'(bus.out_tag), 64'(tag));
        @(posedge clk);
        #1;
    endtask

    logic [31:0] st_a [16] = '{32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000,
                               32'h7FFFFFFF, 32'h12345678, 32'hDEADBEEF, 32'h00010000,
                               32'hFFFF0000, 32'h0000FFFF, 32'h55555555, 32'hAAAAAAAA,
                               32'h80000001, 32'h00000002, 32'hCAFEBABE, 32'h7FFFFFFF};
    logic [31:0] st_b [16] = '{32'h00000005, 32'hFFFFFFFF, 32'h00000002, 32'h80000000,
                               32'h7FFFFFFF, 32'h9ABCDEF0, 32'h00000003, 32'h00010000,
                               32'hFFFF0000, 32'hFFFFFFFF, 32'h00000003, 32'hAAAAAAAA,
                               32'h7FFFFFFF, 32'h80000000, 32'h12345678, 32'h80000000};

    initial begin
        n_tot = 0; n_bad = 0; n_out = 0; cyc = 0; first_cyc = 0; last_cyc = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = OP_MUL;
        bus.in_tag    = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
        chk("rst_result", 64'(bus.out_result), 64'(0));
        chk("rst_tag", 64'(bus.out_tag), 64'(0));
        @(posedge clk);
        #1 reset = 1'b0;

        one_op("mul_ones",   OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'h00000001);
        one_op("xuu_ones",   OP_MULXUU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE);
        one_op("xss_ones",   OP_MULXSS, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'h00000000);
        one_op("xsu_ones",   OP_MULXSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFF);
        one_op("xss_min",    OP_MULXSS, 32'h80000000, 32'h80000000, 5'd5, 32'h40000000);
        one_op("mul_min",    OP_MUL,    32'h80000000, 32'h80000000, 5'd6, 32'h00000000);
        one_op("xsu_neg2x3", OP_MULXSU, 32'hFFFFFFFE, 32'h00000003, 5'd7, 32'hFFFFFFFF);

        // Back-to-back stream: results must emerge on 16 consecutive cycles.
        n_out = 0;
        for (int i = 0; i < 16; i++) send(2'(i), st_a[i], st_b[i], 5'(i));
        repeat (MULT_STAGES + 2) @(posedge clk);
        #1;
        chk("stream_count", 64'(n_out), 64'(16));
        chk("stream_span", 64'(last_cyc - first_cyc), 64'(15));

        // Backpressure: out_ready low for 5 cycles while 4 ops are issued.
        fork
            begin
                for (int k = 0; k < 4; k++) send(2'(k), st_a[k + 4], st_b[k + 8], 5'(20 + k));
            end
            begin
                bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                @(negedge clk);
                chk("stall_in_ready", 64'(bus.in_ready), 64'(0));
                chk("stall_out_valid", 64'(bus.out_valid), 64'(1));
                repeat (2) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;

        // Flush with two ops in flight and a third presented in the same cycle.
        send(OP_MULXUU, 32'h11111111, 32'h22222222, 5'd9);
        send(OP_MUL,    32'h33333333, 32'h44444444, 5'd10);
        bus.in_valid = 1'b1;
        bus.in_op    = OP_MULXSS;
        bus.in_a     = 32'h55555555;
        bus.in_b     = 32'h66666666;
        bus.in_tag   = 5'd11;
        bus.flush    = 1'b1;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_busy", 64'(bus.busy), 64'(0));
        chk("flush_out_valid", 64'(bus.out_valid), 64'(0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("flush_quiet", 64'(bus.out_valid), 64'(0));
        end
        @(posedge clk);
        #1;
        one_op("post_flush", OP_MUL, 32'h00000007, 32'h00000006, 5'd12, 32'h0000002A);

        // Asynchronous reset mid-stream, asserted away from any clock edge.
        for (int k = 0; k < 3; k++) send(OP_MULXUU, 32'h80000000, 32'h00000002, 5'(13 + k));
        #2 reset = 1'b1;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("arst_busy", 64'(bus.busy), 64'(0));
        chk("arst_in_ready", 64'(bus.in_ready), 64'(1));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_rst_quiet", 64'(bus.out_valid | bus.busy), 64'(0));
        end
        @(posedge clk);
        #1;
        one_op("post_rst", OP_MULXUU, 32'h80000000, 32'h00000002, 5'd30, 32'h00000001);

        repeat (4) @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
